// File: rtl/data_ram_responder_pkg.sv
// Shared constants, state encoding and address-range helper for the MEM-stage
// data RAM responder.
package data_ram_responder_pkg;

  localparam int DATA_BUS = 32;
  localparam int ADDR_BUS = 32;
  localparam int WORD_W   = 32;
  localparam int LANES    = 4;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_WAIT = 2'd1,
    ST_RESP = 2'd2
  } state_e;

  // A byte address is outside the array when any bit above the word index is set.
  function automatic logic addr_out_of_range(input logic [ADDR_BUS-1:0] addr,
                                             input int unsigned aw);
    return (addr >> (aw + 2)) != '0;
  endfunction

endpackage

// File: rtl/data_ram_responder_if.sv
// MEM-stage data RAM port bundle; master is the pipeline, slave is the responder.
interface data_ram_responder_if;
  import data_ram_responder_pkg::*;

  // ram_en is the request valid and must stay stable while ram_stall is high;
  // the request is done when ram_resp_valid pulses for one cycle.
  logic                ram_en;
  logic [LANES-1:0]    ram_write_en;
  logic [ADDR_BUS-1:0] ram_addr;
  logic [DATA_BUS-1:0] ram_write_data;
  logic [DATA_BUS-1:0] ram_read_data;
  logic                ram_resp_valid;
  logic                ram_stall;
  logic                ram_addr_err;

  modport master (
    output ram_en, ram_write_en, ram_addr, ram_write_data,
    input  ram_read_data, ram_resp_valid, ram_stall, ram_addr_err
  );

  modport slave (
    input  ram_en, ram_write_en, ram_addr, ram_write_data,
    output ram_read_data, ram_resp_valid, ram_stall, ram_addr_err
  );

endinterface

// File: rtl/byte_lane_sram.sv
// Single-port synchronous SRAM with per-byte write enables and a registered
// read port that holds until the next read or a clear.
module byte_lane_sram
  import data_ram_responder_pkg::*;
#(
  parameter int ADDR_WIDTH = 12
) (
  input  logic                  clk,
  input  logic [ADDR_WIDTH-1:0] addr_i,
  input  logic [LANES-1:0]      we_i,
  input  logic [WORD_W-1:0]     wdata_i,
  input  logic                  re_i,
  input  logic                  clr_i,
  output logic [WORD_W-1:0]     rdata_o
);

  logic [WORD_W-1:0] mem_q [2**ADDR_WIDTH];
  logic [WORD_W-1:0] rdata_q;

  always_ff @(posedge clk) begin
    for (int i = 0; i < LANES; i++) begin
      if (we_i[i]) mem_q[addr_i][8*i +: 8] <= wdata_i[8*i +: 8];
    end
  end

  always_ff @(posedge clk) begin
    if (clr_i)     rdata_q <= '0;
    else if (re_i) rdata_q <= mem_q[addr_i];
  end

  assign rdata_o = rdata_q;

endmodule

// File: rtl/data_ram_responder.sv
// Data RAM responder: latches a MEM-stage request, waits WAIT_CYCLES, performs
// the access on a byte-lane SRAM and pulses a one-cycle response.
module data_ram_responder
  import data_ram_responder_pkg::*;
#(
  parameter int ADDR_WIDTH  = 12,
  parameter int WAIT_CYCLES = 1,
  parameter int CNT_WIDTH   = 4
) (
  input  logic                 clk,
  input  logic                 rst,
  data_ram_responder_if.slave  bus,
  output state_e               state_o
);

  state_e                state_q, state_d;
  logic [CNT_WIDTH-1:0]  cnt_q, cnt_d;
  logic [ADDR_BUS-1:0]   addr_q, addr_d;
  logic [LANES-1:0]      mask_q, mask_d;
  logic [DATA_BUS-1:0]   wdata_q, wdata_d;
  logic                  resp_valid_q, resp_valid_d;
  logic                  addr_err_q, addr_err_d;
  logic                  access;
  logic                  oor;

  logic [LANES-1:0]      sram_we;
  logic                  sram_re;
  logic                  sram_clr;
  logic [WORD_W-1:0]     sram_rdata;

  assign oor = addr_out_of_range(addr_q, ADDR_WIDTH);

  always_comb begin
    state_d      = state_q;
    cnt_d        = cnt_q;
    addr_d       = addr_q;
    mask_d       = mask_q;
    wdata_d      = wdata_q;
    resp_valid_d = 1'b0;
    addr_err_d   = 1'b0;
    access       = 1'b0;
    case (state_q)
      ST_IDLE: begin
        if (bus.ram_en) begin
          addr_d  = bus.ram_addr;
          mask_d  = bus.ram_write_en;
          wdata_d = bus.ram_write_data;
          cnt_d   = CNT_WIDTH'(WAIT_CYCLES - 1);
          state_d = ST_WAIT;
        end
      end
      ST_WAIT: begin
        // Dropping ram_en mid-wait is a flush: abandon without side effects.
        if (!bus.ram_en) begin
          state_d = ST_IDLE;
        end else if (cnt_q != '0) begin
          cnt_d = cnt_q - 1'b1;
        end else begin
          access       = 1'b1;
          resp_valid_d = 1'b1;
          addr_err_d   = oor;
          state_d      = ST_RESP;
        end
      end
      ST_RESP: state_d = ST_IDLE;
      default: state_d = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!rst) begin
      state_q      <= ST_IDLE;
      cnt_q        <= '0;
      addr_q       <= '0;
      mask_q       <= '0;
      wdata_q      <= '0;
      resp_valid_q <= 1'b0;
      addr_err_q   <= 1'b0;
    end else begin
      state_q      <= state_d;
      cnt_q        <= cnt_d;
      addr_q       <= addr_d;
      mask_q       <= mask_d;
      wdata_q      <= wdata_d;
      resp_valid_q <= resp_valid_d;
      addr_err_q   <= addr_err_d;
    end
  end

  // Reset gates the array strobes so an access aborted by reset never writes.
  assign sram_we  = (rst && access && !oor) ? mask_q : '0;
  assign sram_re  = rst && access && !oor && (mask_q == '0);
  assign sram_clr = !rst || (access && oor);

  byte_lane_sram #(
    .ADDR_WIDTH (ADDR_WIDTH)
  ) u_sram (
    .clk     (clk),
    .addr_i  (addr_q[ADDR_WIDTH+1:2]),
    .we_i    (sram_we),
    .wdata_i (wdata_q),
    .re_i    (sram_re),
    .clr_i   (sram_clr),
    .rdata_o (sram_rdata)
  );

  assign bus.ram_read_data  = sram_rdata;
  assign bus.ram_resp_valid = resp_valid_q;
  assign bus.ram_addr_err   = addr_err_q;
  assign bus.ram_stall      = rst && bus.ram_en && (state_q != ST_RESP);
  assign state_o            = state_q;

endmodule

// File: tb/tb_data_ram_responder.sv
// Bench for data_ram_responder: two instances (1 and 4 wait states) share the
// request bus, each with its own memory model and expected-response queue.
module tb_data_ram_responder;
  import data_ram_responder_pkg::*;

  localparam int AW = 12;

  // clock / reset
  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  data_ram_responder_if if1 ();
  data_ram_responder_if if4 ();
  state_e st1, st4;

  logic        en1, en4;
  logic [3:0]  drv_mask;
  logic [31:0] drv_addr, drv_wdata;

  assign if1.ram_en         = en1;
  assign if4.ram_en         = en4;
  assign if1.ram_write_en   = drv_mask;
  assign if4.ram_write_en   = drv_mask;
  assign if1.ram_addr       = drv_addr;
  assign if4.ram_addr       = drv_addr;
  assign if1.ram_write_data = drv_wdata;
  assign if4.ram_write_data = drv_wdata;

  data_ram_responder #(.ADDR_WIDTH(AW), .WAIT_CYCLES(1), .CNT_WIDTH(4)) dut1 (
    .clk (clk), .rst (rst), .bus (if1.slave), .state_o (st1)
  );
  data_ram_responder #(.ADDR_WIDTH(AW), .WAIT_CYCLES(4), .CNT_WIDTH(4)) dut4 (
    .clk (clk), .rst (rst), .bus (if4.slave), .state_o (st4)
  );

  // scoreboard state
  int errors = 0;
  int checks = 0;
  logic [32:0] exp1_q[$];
  logic [32:0] exp4_q[$];
  logic [31:0] mem1[int];
  logic [31:0] mem4[int];
  logic [31:0] last1, last4;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  function automatic int wc(input int sel);
    return (sel == 1) ? 1 : 4;
  endfunction

  function automatic logic resp_of(input int sel);
    return (sel == 1) ? if1.ram_resp_valid : if4.ram_resp_valid;
  endfunction

  function automatic logic stall_of(input int sel);
    return (sel == 1) ? if1.ram_stall : if4.ram_stall;
  endfunction

  // Reference model: byte-addressed memory of 2**AW words, lane-merged writes.
  task automatic model_push(input int sel, input logic [3:0] mask,
                            input logic [31:0] addr, input logic [31:0] wdata);
    logic [32:0] e;
    logic [31:0] cur;
    int idx;
    if (longint'(addr) >= (longint'(1) << (AW + 2))) begin
      e = {1'b1, 32'h0};
      if (sel == 1) last1 = 32'h0; else last4 = 32'h0;
    end else begin
      idx = int'(addr / 4);
      cur = (sel == 1) ? mem1[idx] : mem4[idx];
      if (mask == 4'b0000) begin
        if (sel == 1) last1 = cur; else last4 = cur;
        e = {1'b0, cur};
      end else begin
        for (int l = 0; l < 4; l++)
          if (mask[l]) cur[8*l +: 8] = wdata[8*l +: 8];
        if (sel == 1) mem1[idx] = cur; else mem4[idx] = cur;
        e = {1'b0, (sel == 1) ? last1 : last4};
      end
    end
    if (sel == 1) exp1_q.push_back(e); else exp4_q.push_back(e);
  endtask

  // driver tasks (called at a negedge)
  task automatic set_req(input int sel, input logic [3:0] mask,
                         input logic [31:0] addr, input logic [31:0] wdata);
    drv_mask  = mask;
    drv_addr  = addr;
    drv_wdata = wdata;
    en1 = (sel == 1);
    en4 = (sel == 4);
  endtask

  task automatic idle();
    en1 = 1'b0;
    en4 = 1'b0;
    @(negedge clk);
  endtask

  // b2b: issued during the previous response cycle, so one extra cycle to wait.
  task automatic access(input int sel, input logic [3:0] mask, input logic [31:0] addr,
                        input logic [31:0] wdata, input bit b2b);
    int  lat;
    bit  done;
    set_req(sel, mask, addr, wdata);
    model_push(sel, mask, addr, wdata);
    #1;
    check("stall_issue", stall_of(sel), !b2b);
    lat  = 0;
    done = 0;
    while (!done && lat < 40) begin
      @(negedge clk);
      lat++;
      if (resp_of(sel)) done = 1;
      else check("stall_wait", stall_of(sel), 1);
    end
    if (!done) begin
      checks++;
      errors++;
      $display("FAIL timeout: no response from dut%0d after %0d cycles", sel, lat);
      if (sel == 1) void'(exp1_q.pop_back()); else void'(exp4_q.pop_back());
    end else begin
      check("latency", lat, b2b ? wc(sel) + 2 : wc(sel) + 1);
      check("stall_resp", stall_of(sel), 0);
    end
  endtask

  task automatic abort(input int sel, input logic [3:0] mask, input logic [31:0] addr,
                       input logic [31:0] wdata, input int k);
    set_req(sel, mask, addr, wdata);
    repeat (k) @(negedge clk);
    en1 = 1'b0;
    en4 = 1'b0;
    @(negedge clk);
    check("abort_idle", (sel == 1) ? st1 : st4, ST_IDLE);
    repeat (wc(sel) + 3) @(negedge clk);
  endtask

  // monitor: pop and compare on every response
  always @(negedge clk) begin
    logic [32:0] e;
    if (if1.ram_resp_valid) begin
      if (exp1_q.size() == 0) begin
        checks++; errors++;
        $display("FAIL w1_unexpected_resp: got resp with data %0h, expected none", if1.ram_read_data);
      end else begin
        e = exp1_q.pop_front();
        check("w1_resp", {31'h0, if1.ram_addr_err, if1.ram_read_data}, {31'h0, e});
      end
    end else if (if1.ram_addr_err) check("w1_err_no_resp", 1, 0);
    if (if4.ram_resp_valid) begin
      if (exp4_q.size() == 0) begin
        checks++; errors++;
        $display("FAIL w4_unexpected_resp: got resp with data %0h, expected none", if4.ram_read_data);
      end else begin
        e = exp4_q.pop_front();
        check("w4_resp", {31'h0, if4.ram_addr_err, if4.ram_read_data}, {31'h0, e});
      end
    end else if (if4.ram_addr_err) check("w4_err_no_resp", 1, 0);
  end

  initial begin
    #500000;
    $display("FAIL watchdog: simulation did not finish, got timeout expected completion");
    $fatal(1, "watchdog");
  end

  initial begin
    bit in_resp;
    int r;
    logic [3:0]  m;
    logic [31:0] a;

    // reset held with a request pending
    rst = 1'b0;
    set_req(1, 4'hF, 32'h0, 32'h12345678);
    last1 = '0;
    last4 = '0;
    repeat (2) begin
      @(negedge clk);
      check("rst_stall", if1.ram_stall, 0);
      check("rst_resp", if1.ram_resp_valid, 0);
      check("rst_rdata", if1.ram_read_data, 0);
      check("rst_state", st1, ST_IDLE);
      check("rst_rdata4", if4.ram_read_data, 0);
    end
    rst = 1'b1;
    access(1, 4'hF, 32'h0, 32'h12345678, 0);
    idle();

    // known contents in the address pool
    for (int s = 0; s < 2; s++) begin
      for (int i = 0; i < 34; i++) begin
        access(s == 0 ? 1 : 4, 4'hF, i * 4, (i == 32) ? 32'h0 : $urandom, 0);
        idle();
      end
    end

    // directed sequence on each instance
    for (int s = 0; s < 2; s++) begin
      int sel;
      sel = (s == 0) ? 1 : 4;
      access(sel, 4'hF, 32'h40, 32'hDEADBEEF, 0); idle();
      access(sel, 4'h0, 32'h40, 32'h0, 0);
      access(sel, 4'h0, 32'h40, 32'h0, 1);        idle();
      access(sel, 4'b0100, 32'h40, 32'h00AA0000, 0); idle();
      access(sel, 4'h0, 32'h40, 32'h0, 0);        idle();
      access(sel, 4'b0011, 32'h40, 32'h00001234, 0); idle();
      access(sel, 4'h0, 32'h40, 32'h0, 0);        idle();
      abort(sel, 4'hF, 32'h80, 32'h11111111, wc(sel));
      access(sel, 4'h0, 32'h80, 32'h0, 0);        idle();
      access(sel, 4'hF, 32'h4000, 32'h55555555, 0); idle();
      access(sel, 4'h0, 32'h4000, 32'h0, 0);      idle();
      access(sel, 4'h0, 32'h0, 32'h0, 0);         idle();
    end

    // reset in the middle of a write must not modify the array
    set_req(4, 4'hF, 32'h14, 32'hCAFEF00D);
    repeat (2) @(negedge clk);
    rst = 1'b0;
    en4 = 1'b0;
    @(negedge clk);
    check("midrst_state", st4, ST_IDLE);
    check("midrst_rdata", if4.ram_read_data, 0);
    check("midrst_resp", if4.ram_resp_valid, 0);
    rst = 1'b1;
    last1 = '0;
    last4 = '0;
    @(negedge clk);
    access(4, 4'h0, 32'h14, 32'h0, 0); idle();

    // randomized traffic
    for (int s = 0; s < 2; s++) begin
      int sel;
      sel = (s == 0) ? 1 : 4;
      in_resp = 0;
      for (int n = 0; n < 30; n++) begin
        r = $urandom_range(0, 9);
        m = ($urandom_range(0, 1) == 1) ? 4'h0 : 4'($urandom_range(1, 15));
        if ($urandom_range(0, 7) == 0)
          a = (32'h4000 << $urandom_range(0, 17)) | (32'($urandom_range(0, 1023)) << 2);
        else
          a = 32'($urandom_range(0, 33)) * 4;
        if (r == 0) begin
          if (in_resp) idle();
          abort(sel, m | 4'h1, a, $urandom, $urandom_range(1, wc(sel)));
          in_resp = 0;
        end else begin
          if (in_resp && $urandom_range(0, 1) == 1) begin
            access(sel, m, a, $urandom, 1);
          end else begin
            if (in_resp) idle();
            access(sel, m, a, $urandom, 0);
          end
          in_resp = 1;
        end
      end
      idle();
    end

    repeat (10) @(negedge clk);
    check("q1_empty", exp1_q.size(), 0);
    check("q4_empty", exp4_q.size(), 0);
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
